// File: rtl/vc_demux2_dd_buf_if.sv
// Stream handshake bundle for vc_demux2_dd_buf: one val/rdy message with its 2-bit security domain.
interface vc_demux2_dd_buf_if #(
  parameter int p_nbits = 32
);
  logic               val;
  logic               rdy;
  logic [p_nbits-1:0] msg;
  logic [1:0]         domain;

  modport master (output val, output msg, output domain, input rdy);
  modport slave  (input val, input msg, input domain, output rdy);
endinterface

// File: rtl/vc_demux2_dd_buf.sv
// Domain-tagged 1-to-2 demux with a single-domain FIFO per output.
// Optional macro VC_DEMUX2_DD_SCRUB_EN: zero entries on dequeue and mask outputs while invalid.
module vc_demux2_dd_buf #(
  parameter int p_nbits = 32,
  parameter int p_depth = 2
) (
  input  logic                clk,
  input  logic                reset,
  vc_demux2_dd_buf_if.slave   in_if,
  input  logic                sel,
  vc_demux2_dd_buf_if.master  out0_if,
  vc_demux2_dd_buf_if.master  out1_if
);

  localparam int PW = $clog2(p_depth);
  localparam int CW = PW + 1;
  localparam int EW = p_nbits + 2;
  localparam logic [CW-1:0] FULL_CNT = CW'(p_depth);

  logic [EW-1:0] mem_q     [2][p_depth];
  logic [EW-1:0] mem_d     [2][p_depth];
  logic [PW-1:0] enq_ptr_q [2];
  logic [PW-1:0] enq_ptr_d [2];
  logic [PW-1:0] deq_ptr_q [2];
  logic [PW-1:0] deq_ptr_d [2];
  logic [CW-1:0] cnt_q     [2];
  logic [CW-1:0] cnt_d     [2];

  logic [EW-1:0] head    [2];
  logic          full    [2];
  logic          empty   [2];
  logic          enq     [2];
  logic          deq     [2];
  logic          out_rdy [2];
  logic          in_rdy;

  always_comb begin
    out_rdy[0] = out0_if.rdy;
    out_rdy[1] = out1_if.rdy;
    for (int n = 0; n < 2; n++) begin
      full[n]  = (cnt_q[n] == FULL_CNT);
      empty[n] = (cnt_q[n] == '0);
      head[n]  = mem_q[n][deq_ptr_q[n]];
      deq[n]   = !empty[n] && out_rdy[n];
    end
    // A non-empty FIFO is locked to the domain of what it already holds.
    in_rdy = !full[sel] && (empty[sel] || (in_if.domain == head[sel][EW-1 -: 2]));
    enq[0] = in_if.val && in_rdy && !sel;
    enq[1] = in_if.val && in_rdy && sel;
  end

  always_comb begin
    mem_d     = mem_q;
    enq_ptr_d = enq_ptr_q;
    deq_ptr_d = deq_ptr_q;
    cnt_d     = cnt_q;
    for (int n = 0; n < 2; n++) begin
      // Full blocks enqueue and empty blocks dequeue, so both never touch the same slot.
      if (enq[n]) begin
        mem_d[n][enq_ptr_q[n]] = {in_if.domain, in_if.msg};
        enq_ptr_d[n]           = enq_ptr_q[n] + 1'b1;
      end
      if (deq[n]) begin
`ifdef VC_DEMUX2_DD_SCRUB_EN
        mem_d[n][deq_ptr_q[n]] = '0;
`endif
        deq_ptr_d[n] = deq_ptr_q[n] + 1'b1;
      end
      cnt_d[n] = cnt_q[n] + CW'(enq[n]) - CW'(deq[n]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 2; n++) begin
        enq_ptr_q[n] <= '0;
        deq_ptr_q[n] <= '0;
        cnt_q[n]     <= '0;
        for (int e = 0; e < p_depth; e++) begin
          mem_q[n][e] <= '0;
        end
      end
    end else begin
      mem_q     <= mem_d;
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_if.rdy   = in_rdy;
  assign out0_if.val = !empty[0];
  assign out1_if.val = !empty[1];

`ifdef VC_DEMUX2_DD_SCRUB_EN
  assign out0_if.msg    = empty[0] ? '0 : head[0][p_nbits-1:0];
  assign out0_if.domain = empty[0] ? '0 : head[0][EW-1 -: 2];
  assign out1_if.msg    = empty[1] ? '0 : head[1][p_nbits-1:0];
  assign out1_if.domain = empty[1] ? '0 : head[1][EW-1 -: 2];
`else
  assign out0_if.msg    = head[0][p_nbits-1:0];
  assign out0_if.domain = head[0][EW-1 -: 2];
  assign out1_if.msg    = head[1][p_nbits-1:0];
  assign out1_if.domain = head[1][EW-1 -: 2];
`endif

endmodule

// File: tb/tb_vc_demux2_dd_buf.sv
// Scoreboard bench for vc_demux2_dd_buf: directed pushes queue expected {domain,msg}; a monitor pops on each dequeue.
module tb_vc_demux2_dd_buf;

  logic clk;
  logic reset;
  logic sel;

  vc_demux2_dd_buf_if #(.p_nbits(32)) in_if ();
  vc_demux2_dd_buf_if #(.p_nbits(32)) out0_if ();
  vc_demux2_dd_buf_if #(.p_nbits(32)) out1_if ();

  vc_demux2_dd_buf #(.p_nbits(32), .p_depth(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_if   (in_if),
    .sel     (sel),
    .out0_if (out0_if),
    .out1_if (out1_if)
  );

  int total = 0;
  int bad   = 0;
  logic [33:0] q0 [$];
  logic [33:0] q1 [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (out0_if.val && out0_if.rdy) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL out0_extra: got %0h want nothing", {out0_if.domain, out0_if.msg});
        end else begin
          chk("out0_data", {out0_if.domain, out0_if.msg}, q0.pop_front());
        end
      end
      if (out1_if.val && out1_if.rdy) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL out1_extra: got %0h want nothing", {out1_if.domain, out1_if.msg});
        end else begin
          chk("out1_data", {out1_if.domain, out1_if.msg}, q1.pop_front());
        end
      end
    end
  end

  task automatic send(bit s, logic [1:0] d, logic [31:0] m, bit exp_rdy, string nm);
    in_if.val = 1'b1; sel = s; in_if.domain = d; in_if.msg = m;
    #1;
    chk(nm, in_if.rdy, exp_rdy);
    if (exp_rdy) begin
      if (s) q1.push_back({d, m});
      else   q0.push_back({d, m});
    end
    @(posedge clk); #1;
    in_if.val = 1'b0;
  endtask

  task automatic drain(string nm);
    for (int i = 0; i < 40; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: pending out0=%0d out1=%0d want 0", nm, q0.size(), q1.size());
    end
    chk({nm, "_out0_val"}, out0_if.val, 1'b0);
    chk({nm, "_out1_val"}, out1_if.val, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sel = 1'b0;
    in_if.val = 1'b0; in_if.msg = '0; in_if.domain = '0;
    out0_if.rdy = 1'b0; out1_if.rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_in_rdy", in_if.rdy, 1'b1);
    chk("rst_out0_val", out0_if.val, 1'b0);
    chk("rst_out1_val", out1_if.val, 1'b0);
    chk("rst_out0_msg", out0_if.msg, 32'h0);
    chk("rst_out0_dom", out0_if.domain, 2'd0);
    chk("rst_out1_msg", out1_if.msg, 32'h0);
    @(posedge clk); #1;

    // 1: single message to out0, one cycle latency
    in_if.val = 1'b1; sel = 1'b0; in_if.msg = 32'hA5; in_if.domain = 2'd1;
    #1;
    chk("t1_in_rdy", in_if.rdy, 1'b1);
    chk("t1_no_comb_path", out0_if.val, 1'b0);
    q0.push_back({2'd1, 32'hA5});
    @(posedge clk); #1;
    in_if.val = 1'b0;
    chk("t1_out0_val", out0_if.val, 1'b1);
    chk("t1_out0_msg", out0_if.msg, 32'hA5);
    chk("t1_out0_dom", out0_if.domain, 2'd1);
    chk("t1_out1_val", out1_if.val, 1'b0);
    out0_if.rdy = 1'b1;
    drain("t1");

    // 2: fill out1, third push stalls, out0 still open
    out1_if.rdy = 1'b0;
    send(1'b1, 2'd2, 32'h11, 1'b1, "t2_push1");
    send(1'b1, 2'd2, 32'h22, 1'b1, "t2_push2");
    send(1'b1, 2'd2, 32'h33, 1'b0, "t2_full_stall");
    chk("t2_out1_val", out1_if.val, 1'b1);
    send(1'b0, 2'd2, 32'h44, 1'b1, "t2_other_port");
    out1_if.rdy = 1'b1;
    drain("t2");

    // 3: domain lock on out0 until it drains
    out0_if.rdy = 1'b0;
    send(1'b0, 2'd1, 32'h31, 1'b1, "t3_dom1");
    in_if.val = 1'b1; sel = 1'b0; in_if.domain = 2'd3; in_if.msg = 32'h32;
    #1 chk("t3_lock", in_if.rdy, 1'b0);
    @(posedge clk); #1;
    chk("t3_lock_hold", in_if.rdy, 1'b0);
    out0_if.rdy = 1'b1;
    #1 chk("t3_lock_release_rdy", in_if.rdy, 1'b0);
    @(posedge clk); #1;
    chk("t3_accept", in_if.rdy, 1'b1);
    q0.push_back({2'd3, 32'h32});
    @(posedge clk); #1;
    in_if.val = 1'b0;
    drain("t3");

    // 4: pointer wrap at full throughput
    for (int i = 1; i <= 7; i++) send(1'b0, 2'd0, 32'(i), 1'b1, "t4_stream");
    drain("t4");

    // 5: reset with both FIFOs holding entries
    out0_if.rdy = 1'b0; out1_if.rdy = 1'b0;
    send(1'b0, 2'd1, 32'h51, 1'b1, "t5_q0a");
    send(1'b1, 2'd2, 32'h52, 1'b1, "t5_q1");
    send(1'b0, 2'd1, 32'h53, 1'b1, "t5_q0b");
    send(1'b0, 2'd1, 32'h56, 1'b0, "t5_q0_full");
    chk("t5_pre_out0_val", out0_if.val, 1'b1);
    chk("t5_pre_out1_val", out1_if.val, 1'b1);
    reset = 1'b1;
    #1;
    chk("t5_rst_out0_val", out0_if.val, 1'b0);
    chk("t5_rst_out1_val", out1_if.val, 1'b0);
    chk("t5_rst_in_rdy", in_if.rdy, 1'b1);
    q0.delete(); q1.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    out0_if.rdy = 1'b1; out1_if.rdy = 1'b1;
    send(1'b0, 2'd2, 32'h54, 1'b1, "t5_after_out0");
    send(1'b1, 2'd3, 32'h55, 1'b1, "t5_after_out1");
    drain("t5");

    // 6: output after last dequeue
    send(1'b0, 2'd2, 32'hDEAD, 1'b1, "t6_push");
    @(posedge clk); #1;
    chk("t6_out0_val", out0_if.val, 1'b0);
`ifdef VC_DEMUX2_DD_SCRUB_EN
    chk("t6_scrub_msg", out0_if.msg, 32'h0);
    chk("t6_scrub_dom", out0_if.domain, 2'd0);
`endif
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
